frame_response_scheduler: RTL
=============================

# frame_response_scheduler

Round-robin scheduler that shares the single response Frame_Builder among several response sources: the AXI read path, the AXI write path and the protocol-error path. It accepts one response descriptor at a time through a per-requester valid/ready handshake. It launches the builder with a one-cycle `build_response` pulse and holds the descriptor stable until the frame completes. It then enforces an inter-frame gap before the next grant. It sits between the bridge command/AXI logic and the Frame_Builder/UART TX path.

## Interface
- NUM_REQ, 3, number of requesters (2..8); IDX_W = $clog2(NUM_REQ), min 1
- GAP_CYCLES, 2, idle cycles after `response_complete` before the next grant (0 allowed)
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_DONE (used only with watchdog compiled in)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester descriptor valid
- req_ready  out  NUM_REQ  one-hot accept, combinational
- req_status  in  NUM_REQ*8  status code, requester i at [8i+7:8i]
- req_cmd  in  NUM_REQ*8  command echo
- req_addr  in  NUM_REQ*32  address echo
- req_count  in  NUM_REQ*6  response data byte count
- req_is_read  in  NUM_REQ  read-response flag
- fb_status_code, fb_cmd_echo, fb_addr_echo, fb_data_count, fb_is_read  out  8/8/32/6/1  registered descriptor to the builder
- fb_build_response  out  1  launch pulse
- fb_builder_busy  in  1  builder busy
- fb_response_complete  in  1  builder completion pulse
- grant_idx  out  IDX_W  current owner; the external data-array mux selects on it
- sched_busy  out  1  state != IDLE
- frames_sent  out  16  completed-frame count, wraps 0xFFFF->0
- timeout_err  out  1  sticky watchdog flag
- err_clear  in  1  clears timeout_err

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE behaviour:
  - Grant only if any req_valid and !fb_builder_busy.
  - Winner is the first valid index searching from last_grant+1 modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle.
  - At the clock edge: latch the descriptor into the fb_* registers, set grant_idx=winner and last_grant=winner, then go to LAUNCH.
- LAUNCH: fb_build_response=1 for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE behaviour:
  - On fb_response_complete: increment frames_sent.
  - Then go to GAP if GAP_CYCLES>0, else go to IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- req_ready is 0 in every state except IDLE.
- fb_* outputs and grant_idx hold their values until the next grant.
- fb_response_complete is ignored outside WAIT_DONE.
- err_clear clears timeout_err. If err_clear coincides with a new timeout, set wins.
- Reset:
  - state=IDLE, req_ready=0, fb_build_response=0, all fb_* outputs =0, grant_idx=0.
  - last_grant=NUM_REQ-1, so requester 0 has priority first.
  - frames_sent=0, timeout_err=0, sched_busy=0.
- Reset asserted mid-frame aborts immediately. The builder's own reset is external.

## Timing
- req_valid seen in IDLE at cycle N: req_ready at N, fb_build_response high during N+1, state WAIT_DONE from N+2.
- fb_build_response is never high in two consecutive cycles. This guarantees the builder sees a rising edge.
- Complete seen at cycle M: state is GAP from M+1 and IDLE at M+1+GAP_CYCLES. The earliest next req_ready is at cycle M+1+GAP_CYCLES.
- frames_sent updates at edge M+1.
- A requester must hold its descriptor stable while req_valid is high and req_ready is low.

## Configuration
- FRAME_SCHED_WATCHDOG_EN defined:
  - In WAIT_DONE a 16-bit counter, cleared on LAUNCH, increments each cycle.
  - When the count reaches TIMEOUT_CYCLES without completion: set timeout_err, go to GAP, and do not increment frames_sent.
  - Completion on the same cycle as the limit counts as success.
- Undefined: WAIT_DONE waits indefinitely; timeout_err is tied to 0; err_clear is unused.

## Test plan
- Single request: req_valid[1] with status=0x00, cmd=0xA0, addr=0x1000_0004, count=4 -> req_ready[1] same cycle; one fb_build_response pulse next cycle with fb_cmd_echo=0xA0; complete -> frames_sent=1.
- Fairness: all three valid continuously for 6 frames -> grant order 0,1,2,0,1,2.
- Gap: GAP_CYCLES=2, complete at cycle M with req_valid pending -> req_ready first at M+3.
- Builder busy: fb_builder_busy=1 in IDLE with req_valid -> no req_ready until busy drops.
- Watchdog (macro on, TIMEOUT_CYCLES=16): no complete -> timeout_err=1 at 16 cycles after WAIT_DONE entry and frames_sent unchanged; err_clear -> 0.
- Async reset asserted in WAIT_DONE -> all outputs at reset values immediately; next grant goes to requester 0.

Source files
------------

// File: rtl/frame_response_scheduler_if.sv
// Request/builder bundle for the frame response scheduler: per-requester
// descriptor handshake plus the registered descriptor and launch/complete to the Frame_Builder.
interface frame_response_scheduler_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*8-1:0]  req_status;
  logic [NUM_REQ*8-1:0]  req_cmd;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*6-1:0]  req_count;
  logic [NUM_REQ-1:0]    req_is_read;

  logic [7:0]  fb_status_code;
  logic [7:0]  fb_cmd_echo;
  logic [31:0] fb_addr_echo;
  logic [5:0]  fb_data_count;
  logic        fb_is_read;
  logic        fb_build_response;
  logic        fb_builder_busy;
  logic        fb_response_complete;

  // Requesters and the builder together form the environment side.
  modport master (
    output req_valid, req_status, req_cmd, req_addr, req_count, req_is_read,
    input  req_ready,
    input  fb_status_code, fb_cmd_echo, fb_addr_echo, fb_data_count, fb_is_read,
    input  fb_build_response,
    output fb_builder_busy, fb_response_complete
  );

  modport slave (
    input  req_valid, req_status, req_cmd, req_addr, req_count, req_is_read,
    output req_ready,
    output fb_status_code, fb_cmd_echo, fb_addr_echo, fb_data_count, fb_is_read,
    output fb_build_response,
    input  fb_builder_busy, fb_response_complete
  );
endinterface

// File: rtl/frame_response_scheduler.sv
// Round-robin arbiter sharing one Frame_Builder among response sources, with inter-frame gap.
// Optional WAIT_DONE watchdog is compiled in with `define FRAME_SCHED_WATCHDOG_EN.
module frame_response_scheduler #(
  parameter int NUM_REQ        = 3,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  frame_response_scheduler_if.slave bus,
  output logic [IDX_W-1:0]        grant_idx_o,
  output logic                    sched_busy_o,
  output logic [15:0]             frames_sent_o,
  output logic                    timeout_err_o,
  input  logic                    err_clear_i
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  last_q, grant_q, win;
  logic              found, grant_fire, done_ok;
  logic [GAP_W-1:0]  gap_q;
  logic [15:0]       frames_q;
  logic [7:0]        status_q, cmd_q, sel_status, sel_cmd;
  logic [31:0]       addr_q, sel_addr;
  logic [5:0]        count_q, sel_count;
  logic              is_read_q, sel_is_read;
`ifdef FRAME_SCHED_WATCHDOG_EN
  logic [15:0]       wd_q;
  logic              wd_hit;
  logic              timeout_q;
`endif

  // First valid index strictly above last_q, else wrap to the lowest valid index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[k] && (IDX_W'(k) > last_q)) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[k]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    sel_status  = '0;
    sel_cmd     = '0;
    sel_addr    = '0;
    sel_count   = '0;
    sel_is_read = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IDX_W'(k)) begin
        sel_status  = bus.req_status[8*k +: 8];
        sel_cmd     = bus.req_cmd[8*k +: 8];
        sel_addr    = bus.req_addr[32*k +: 32];
        sel_count   = bus.req_count[6*k +: 6];
        sel_is_read = bus.req_is_read[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    done_ok    = 1'b0;
`ifdef FRAME_SCHED_WATCHDOG_EN
    wd_hit     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found && !bus.fb_builder_busy) begin
          grant_fire = 1'b1;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.fb_response_complete) begin
          done_ok = 1'b1;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
`ifdef FRAME_SCHED_WATCHDOG_EN
        else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
          wd_hit  = 1'b1;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // req_ready is masked during reset so an asserted requester never sees a spurious accept.
  always_comb begin
    bus.req_ready         = '0;
    bus.fb_build_response = (state_q == S_LAUNCH);
    sched_busy_o          = (state_q != S_IDLE);
    if (!rst && grant_fire) bus.req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q  <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      is_read_q <= 1'b0;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      gap_q     <= '0;
      frames_q  <= '0;
    end else begin
      if (grant_fire) begin
        status_q  <= sel_status;
        cmd_q     <= sel_cmd;
        addr_q    <= sel_addr;
        count_q   <= sel_count;
        is_read_q <= sel_is_read;
        grant_q   <= win;
        last_q    <= win;
      end
      if (state_q == S_GAP) gap_q <= gap_q + 1'b1;
      else                  gap_q <= '0;
      if (done_ok) frames_q <= frames_q + 16'd1;
    end
  end

`ifdef FRAME_SCHED_WATCHDOG_EN
  // A timeout on the same cycle as err_clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_LAUNCH)    wd_q <= '0;
      else if (state_q == S_WAIT) wd_q <= wd_q + 16'd1;
      if (wd_hit)           timeout_q <= 1'b1;
      else if (err_clear_i) timeout_q <= 1'b0;
    end
  end
  assign timeout_err_o = timeout_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear_i;
  assign timeout_err_o    = 1'b0;
`endif

  assign bus.fb_status_code = status_q;
  assign bus.fb_cmd_echo    = cmd_q;
  assign bus.fb_addr_echo   = addr_q;
  assign bus.fb_data_count  = count_q;
  assign bus.fb_is_read     = is_read_q;
  assign grant_idx_o        = grant_q;
  assign frames_sent_o      = frames_q;
endmodule
